// File: rtl/blink_sched.sv
// blink_sched: shares one LED between requesters as timed ON/OFF blink jobs.
// Define BLINK_SCHED_RR_EN for round-robin arbitration (default: fixed priority).
module blink_sched #(
    parameter int NUM_REQ  = 2,
    parameter int TICK_DIV = 12000,
    parameter int CNT_W    = 16,
    parameter int REP_W    = 4,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*CNT_W-1:0] req_on,
    input  logic [NUM_REQ*CNT_W-1:0] req_off,
    input  logic [NUM_REQ*REP_W-1:0] req_reps,
    input  logic                     abort,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [GW-1:0]            grant_id,
    output logic                     led
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] on_q, on_d;
    logic [CNT_W-1:0] off_q, off_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [GW-1:0]    gid_q, gid_d;
    logic             led_q, led_d;

    logic             found;
    logic [GW-1:0]    win;
    logic [CNT_W-1:0] on_w, off_w, on_len;
    logic [REP_W-1:0] reps_w;
    logic             tick, on_end, off_end, last_rep;

`ifdef BLINK_SCHED_RR_EN
    logic [GW-1:0]          rr_q, rr_d;
    logic [2*NUM_REQ-1:0]   dbl;
    logic [NUM_REQ-1:0]     rot;

    // Rotate the request vector so index 0 is the search start.
    always_comb begin
        found = 1'b0;
        win   = '0;
        dbl   = {req_valid, req_valid} >> rr_q;
        rot   = dbl[NUM_REQ-1:0];
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                if (int'(rr_q) + i >= NUM_REQ) begin
                    win = GW'(int'(rr_q) + i - NUM_REQ);
                end else begin
                    win = GW'(int'(rr_q) + i);
                end
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (state_q == S_IDLE && found) begin
            if (int'(win) + 1 >= NUM_REQ) begin
                rr_d = '0;
            end else begin
                rr_d = win + GW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found = 1'b1;
                win   = GW'(i);
            end
        end
    end
`endif

    assign on_w   = req_on[int'(win)*CNT_W +: CNT_W];
    assign off_w  = req_off[int'(win)*CNT_W +: CNT_W];
    assign reps_w = req_reps[int'(win)*REP_W +: REP_W];

    assign tick     = (presc_q == PW'(TICK_DIV - 1));
    assign on_len   = (on_q == '0) ? CNT_W'(1) : on_q;
    assign on_end   = tick && (cnt_q == on_len - CNT_W'(1));
    assign off_end  = tick && (cnt_q == off_q - CNT_W'(1));
    assign last_rep = (reps_q <= REP_W'(1));

    always_comb begin
        state_d = state_q;
        presc_d = tick ? '0 : presc_q + PW'(1);
        cnt_d   = tick ? cnt_q + CNT_W'(1) : cnt_q;
        on_d    = on_q;
        off_d   = off_q;
        reps_d  = reps_q;
        gid_d   = gid_q;
        led_d   = (state_q == S_ON) && !abort;
        unique case (state_q)
            S_IDLE: begin
                presc_d = '0;
                cnt_d   = '0;
                if (found) begin
                    on_d    = on_w;
                    off_d   = off_w;
                    reps_d  = (reps_w == '0) ? REP_W'(1) : reps_w;
                    gid_d   = win;
                    state_d = S_ON;
                end
            end
            S_ON: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (on_end) begin
                    presc_d = '0;
                    cnt_d   = '0;
                    if (off_q != '0) begin
                        state_d = S_OFF;
                    end else begin
                        reps_d  = reps_q - REP_W'(1);
                        state_d = last_rep ? S_DONE : S_ON;
                    end
                end
            end
            S_OFF: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (off_end) begin
                    presc_d = '0;
                    cnt_d   = '0;
                    reps_d  = reps_q - REP_W'(1);
                    state_d = last_rep ? S_DONE : S_ON;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            cnt_q   <= '0;
            on_q    <= '0;
            off_q   <= '0;
            reps_q  <= '0;
            gid_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            on_q    <= on_d;
            off_q   <= off_d;
            reps_q  <= reps_d;
            gid_q   <= gid_d;
            led_q   <= led_d;
        end
    end

    assign req_ready = (state_q == S_IDLE && found) ? (NUM_REQ'(1) << win) : '0;
    assign done      = (state_q == S_DONE) ? (NUM_REQ'(1) << gid_q) : '0;
    assign busy      = (state_q != S_IDLE);
    assign grant_id  = gid_q;
    assign led       = led_q;

endmodule

// File: tb/tb_blink_sched.sv
// tb_blink_sched: directed and random blink jobs checked against a
// timeline model that expands each accepted job into per-cycle phases.
module tb_blink_sched;

    localparam int N  = 2;
    localparam int TD = 4;
    localparam int CW = 16;
    localparam int RW = 4;
    localparam int P_IDLE = 0;
    localparam int P_ON   = 1;
    localparam int P_OFF  = 2;
    localparam int P_DONE = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*CW-1:0] req_on;
    logic [N*CW-1:0] req_off;
    logic [N*RW-1:0] req_reps;
    logic            abort;
    logic [N-1:0]    done;
    logic            busy;
    logic [0:0]      grant_id;
    logic            led;

    blink_sched #(
        .NUM_REQ (N),
        .TICK_DIV(TD),
        .CNT_W   (CW),
        .REP_W   (RW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_on   (req_on),
        .req_off  (req_off),
        .req_reps (req_reps),
        .abort    (abort),
        .done     (done),
        .busy     (busy),
        .grant_id (grant_id),
        .led      (led)
    );

    always #5 clk = ~clk;

    int   cur;
    int   ph[$];
    logic m_led;
    int   m_gid;
    int   m_rr;
    int   acc_cnt;
    int   last_acc;
    int   n_chk;
    int   n_pass;

    function automatic int arb(logic [N-1:0] v, int rr);
        int idx;
`ifdef BLINK_SCHED_RR_EN
        for (int k = 0; k < N; k++) begin
            idx = (rr + k) % N;
            if (v[idx]) return idx;
        end
`else
        for (int k = 0; k < N; k++) begin
            idx = k;
            if (v[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    // Advance the model across one rising edge using the inputs present at it.
    task automatic model_edge();
        int   w, onl, offl, rp;
        logic nl;
        nl = (cur == P_ON) && !abort;
        if (!rst_n) begin
            cur = P_IDLE;
            ph.delete();
            m_led = 1'b0;
            m_gid = 0;
            m_rr  = 0;
            return;
        end
        m_led = nl;
        if ((cur == P_ON || cur == P_OFF) && abort) begin
            cur = P_IDLE;
            ph.delete();
        end else if (cur == P_IDLE) begin
            w = arb(req_valid, m_rr);
            if (w >= 0) begin
                onl  = int'(req_on[w*CW +: CW]);
                offl = int'(req_off[w*CW +: CW]);
                rp   = int'(req_reps[w*RW +: RW]);
                if (onl == 0) onl = 1;
                if (rp == 0) rp = 1;
                for (int r = 0; r < rp; r++) begin
                    repeat (onl * TD) ph.push_back(P_ON);
                    repeat (offl * TD) ph.push_back(P_OFF);
                end
                ph.push_back(P_DONE);
                m_gid    = w;
                m_rr     = (w + 1) % N;
                acc_cnt  = acc_cnt + 1;
                last_acc = w;
                cur      = ph.pop_front();
            end
        end else begin
            cur = (ph.size() > 0) ? ph.pop_front() : P_IDLE;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        int          w;
        logic [31:0] e_rdy, e_done;
        w      = arb(req_valid, m_rr);
        e_rdy  = (cur == P_IDLE && w >= 0) ? (32'd1 << w) : 32'd0;
        e_done = (cur == P_DONE) ? (32'd1 << m_gid) : 32'd0;
        chk("led", 32'(led), 32'(m_led));
        chk("busy", 32'(busy), 32'(cur != P_IDLE));
        chk("done", 32'(done), e_done);
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("req_ready", 32'(req_ready), e_rdy);
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(negedge clk);
            check_outputs();
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    task automatic set_job(int id, int on, int off, int reps);
        req_on[id*CW +: CW]   = CW'(on);
        req_off[id*CW +: CW]  = CW'(off);
        req_reps[id*RW +: RW] = RW'(reps);
    endtask

    task automatic scramble();
        req_on   = {$urandom, $urandom};
        req_off  = {$urandom, $urandom};
        req_reps = RW*N'($urandom);
    endtask

    // id < 0 waits for any accept.
    task automatic wait_acc(int id, int budget);
        int start, k;
        start = acc_cnt;
        k     = 0;
        while (!(acc_cnt > start && (id < 0 || last_acc == id)) && k < budget) begin
            cyc(1);
            k++;
        end
        n_chk++;
        assert (acc_cnt > start && (id < 0 || last_acc == id)) n_pass++;
        else $error("FAIL accept_timeout observed=%0d expected=%0d", last_acc, id);
    endtask

    task automatic wait_phase(int p, int budget);
        int k;
        k = 0;
        while (cur != p && k < budget) begin
            cyc(1);
            k++;
        end
        n_chk++;
        assert (cur == p) n_pass++;
        else $error("FAIL phase_timeout observed=%0d expected=%0d", cur, p);
    endtask

    initial begin
        cur      = P_IDLE;
        m_led    = 1'b0;
        m_gid    = 0;
        m_rr     = 0;
        acc_cnt  = 0;
        last_acc = -1;
        n_chk    = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        abort    = 1'b0;
        req_valid = '0;
        req_on   = '0;
        req_off  = '0;
        req_reps = '0;
        @(posedge clk);
        model_edge();
        #1;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // single job: 8 cycles lit, 4 dark, one done
        set_job(0, 2, 1, 1);
        req_valid = 2'b01;
        cyc(1);
        req_valid = '0;
        scramble();
        cyc(20);

        // two simultaneous requesters
        set_job(0, 1, 1, 1);
        set_job(1, 2, 0, 2);
        req_valid = 2'b11;
        wait_acc(0, 10);
        req_valid = 2'b10;
        wait_acc(1, 40);
        req_valid = '0;
        cyc(25);

        // held requests for four jobs
        set_job(0, 1, 0, 1);
        set_job(1, 1, 1, 1);
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) wait_acc(-1, 40);
        req_valid = '0;
        cyc(15);

        // on=0 off=0 reps=3: continuous 12-cycle light
        set_job(0, 0, 0, 3);
        req_valid = 2'b01;
        wait_acc(0, 5);
        req_valid = '0;
        scramble();
        cyc(18);

        // abort mid-ON, then immediate new job
        set_job(0, 3, 2, 5);
        req_valid = 2'b01;
        wait_acc(0, 5);
        req_valid = '0;
        cyc(5);
        abort = 1'b1;
        set_job(1, 1, 1, 1);
        req_valid = 2'b10;
        cyc(1);
        abort = 1'b0;
        wait_acc(1, 3);
        req_valid = '0;
        cyc(12);

        // reset during OFF with a pending request
        set_job(0, 1, 3, 2);
        req_valid = 2'b01;
        wait_acc(0, 5);
        req_valid = '0;
        wait_phase(P_OFF, 20);
        cyc(2);
        set_job(1, 2, 1, 1);
        req_valid = 2'b10;
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        wait_acc(1, 3);
        req_valid = '0;
        cyc(16);

        // random traffic
        for (int t = 0; t < 1500; t++) begin
            req_valid = N'($urandom);
            for (int r = 0; r < N; r++) begin
                set_job(r, int'($urandom_range(3)), int'($urandom_range(3)),
                        int'($urandom_range(3)));
            end
            abort = ($urandom_range(39) == 0);
            rst_n = ($urandom_range(299) != 0);
            cyc(1);
        end
        abort = 1'b0;
        rst_n = 1'b1;
        req_valid = '0;
        cyc(100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
